// File: rtl/ace_pkg.sv
// Shared core constants for the fetch/decode front end.
// Default datapath widths and the lane counts used to build the instruction buffer.
package ace_pkg;

    localparam int DEF_INST_W     = 32;
    localparam int DEF_PC_W       = 64;
    localparam int FETCH_LANES    = 8;
    localparam int DECODE_LANES   = 4;
    localparam int ACE_IBUF_DEPTH = 16;

endpackage

// File: rtl/ace_instbuf_if.sv
// Fetch-side write port and decode-side read port of the instruction buffer.
// Write handshake: a beat is taken only when |wr_vld_i && !full_o && !flush_i; otherwise fetch
// holds wr_* unchanged. Read handshake: rd_vld_o marks the oldest entries, decode returns
// rd_pop_i <= popcount(rd_vld_o) and those entries leave at the same edge.
interface ace_instbuf_if
    import ace_pkg::*;
#(
    parameter int DEPTH    = ACE_IBUF_DEPTH,
    parameter int WR_LANES = FETCH_LANES,
    parameter int RD_LANES = DECODE_LANES,
    parameter int INST_W   = DEF_INST_W,
    parameter int PC_W     = DEF_PC_W
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RP_W  = $clog2(RD_LANES + 1);

    logic                         flush_i;
    logic [WR_LANES-1:0]          wr_vld_i;
    logic [WR_LANES*INST_W-1:0]   wr_inst_i;
    logic [WR_LANES*PC_W-1:0]     wr_pc_i;
    logic                         full_o;
    logic [RD_LANES-1:0]          rd_vld_o;
    logic [RD_LANES*INST_W-1:0]   rd_inst_o;
    logic [RD_LANES*PC_W-1:0]     rd_pc_o;
    logic [RP_W-1:0]              rd_pop_i;
    logic                         empty_o;
    logic [CNT_W-1:0]             count_o;

    modport master (
        output flush_i, wr_vld_i, wr_inst_i, wr_pc_i, rd_pop_i,
        input  full_o, rd_vld_o, rd_inst_o, rd_pc_o, empty_o, count_o
    );

    modport slave (
        input  flush_i, wr_vld_i, wr_inst_i, wr_pc_i, rd_pop_i,
        output full_o, rd_vld_o, rd_inst_o, rd_pc_o, empty_o, count_o
    );

endinterface

// File: rtl/ace_lane_compact.sv
// Turns a lane valid mask into per-lane packed slot offsets (exclusive prefix sum) and a total.
// Purely combinational so rename can reuse it for its own lane compaction.
module ace_lane_compact
    import ace_pkg::*;
#(
    parameter int WR_LANES = FETCH_LANES,
    localparam int CW      = $clog2(WR_LANES + 1)
) (
    input  logic [WR_LANES-1:0]         vld,
    output logic [WR_LANES-1:0][CW-1:0] offset,
    output logic [CW-1:0]               n_wr
);

    always_comb begin
        logic [CW-1:0] acc;
        acc = '0;
        for (int i = 0; i < WR_LANES; i++) begin
            offset[i] = acc;
            acc       = acc + CW'(vld[i]);
        end
        n_wr = acc;
    end

endmodule

// File: rtl/ace_instbuf.sv
// Circular instruction buffer between fetch and decode: compacted multi-lane writes,
// oldest-first multi-lane reads with partial pop, and retire flush.
module ace_instbuf
    import ace_pkg::*;
#(
    parameter int DEPTH    = ACE_IBUF_DEPTH,
    parameter int WR_LANES = FETCH_LANES,
    parameter int RD_LANES = DECODE_LANES,
    parameter int INST_W   = DEF_INST_W,
    parameter int PC_W     = DEF_PC_W
) (
    input  logic         clock,
    input  logic         reset_n,
    ace_instbuf_if.slave bus
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CW    = $clog2(WR_LANES + 1);

    logic [PW-1:0]               head_q;
    logic [PW-1:0]               tail_q;
    logic [CNT_W-1:0]            count_q;
    logic [INST_W-1:0]           mem_inst [DEPTH];
    logic [PC_W-1:0]             mem_pc   [DEPTH];

    logic [WR_LANES-1:0][CW-1:0] offset;
    logic [CW-1:0]               n_wr;
    logic [WR_LANES-1:0][PW-1:0] slot;
    logic                        full;
    logic                        wr_acc;
    logic [CNT_W-1:0]            n_acc;
    logic [CNT_W-1:0]            avail;
    logic [CNT_W-1:0]            pop_req;
    logic [CNT_W-1:0]            pop;

    ace_lane_compact #(.WR_LANES(WR_LANES)) u_compact (
        .vld    (bus.wr_vld_i),
        .offset (offset),
        .n_wr   (n_wr)
    );

    // Full is judged on the registered count only, ignoring a same-cycle pop, so fetch
    // stall never depends combinationally on decode.
    assign full    = (CNT_W'(DEPTH) - count_q) < CNT_W'(WR_LANES);
    assign wr_acc  = (|bus.wr_vld_i) && !full && !bus.flush_i;
    assign n_acc   = wr_acc ? CNT_W'(n_wr) : '0;
    assign avail   = (count_q < CNT_W'(RD_LANES)) ? count_q : CNT_W'(RD_LANES);
    assign pop_req = CNT_W'(bus.rd_pop_i);
    assign pop     = bus.flush_i ? '0 : ((pop_req > avail) ? avail : pop_req);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (bus.flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PW'(pop);
            tail_q  <= tail_q + PW'(n_acc);
            count_q <= count_q + n_acc - pop;
        end
    end

    always_comb begin
        for (int i = 0; i < WR_LANES; i++) begin
            slot[i] = tail_q + PW'(offset[i]);
        end
    end

    // Storage carries no reset; count_q alone decides which slots are meaningful.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            for (int i = 0; i < WR_LANES; i++) begin
                if (bus.wr_vld_i[i]) begin
                    mem_inst[slot[i]] <= bus.wr_inst_i[i*INST_W +: INST_W];
                    mem_pc[slot[i]]   <= bus.wr_pc_i[i*PC_W +: PC_W];
                end
            end
        end
    end

    always_comb begin
        bus.rd_vld_o  = '0;
        bus.rd_inst_o = '0;
        bus.rd_pc_o   = '0;
        for (int i = 0; i < RD_LANES; i++) begin
            if (32'(count_q) > i) begin
                bus.rd_vld_o[i]                   = 1'b1;
                bus.rd_inst_o[i*INST_W +: INST_W] = mem_inst[head_q + PW'(i)];
                bus.rd_pc_o[i*PC_W +: PC_W]       = mem_pc[head_q + PW'(i)];
            end
        end
    end

    assign bus.full_o  = full;
    assign bus.empty_o = (count_q == '0);
    assign bus.count_o = count_q;

endmodule

// File: tb/tb_ace_instbuf.sv
// Directed plus randomised bench for ace_instbuf with a FIFO scoreboard of {pc, inst} entries.
module tb_ace_instbuf;

    localparam int DEPTH  = 16;
    localparam int WRL    = 8;
    localparam int RDL    = 4;
    localparam int INST_W = 32;
    localparam int PC_W   = 64;

    logic clock;
    logic reset_n;

    ace_instbuf_if #(
        .DEPTH(DEPTH), .WR_LANES(WRL), .RD_LANES(RDL), .INST_W(INST_W), .PC_W(PC_W)
    ) bus ();

    ace_instbuf #(
        .DEPTH(DEPTH), .WR_LANES(WRL), .RD_LANES(RDL), .INST_W(INST_W), .PC_W(PC_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic [PC_W+INST_W-1:0] exp_q[$];
    int                     n_pass;
    int                     n_total;
    logic [INST_W-1:0]      last_inst [WRL];
    logic [PC_W-1:0]        last_pc   [WRL];
    logic [PC_W-1:0]        pc_ctr;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // scoreboard compare of every output against the model queue
    task automatic check_state(input string tag);
        int sz;
        sz = exp_q.size();
        chk($sformatf("%s_count", tag), 128'(bus.count_o), 128'(sz));
        chk($sformatf("%s_empty", tag), 128'(bus.empty_o), 128'(sz == 0));
        chk($sformatf("%s_full", tag), 128'(bus.full_o), 128'((DEPTH - sz) < WRL));
        for (int i = 0; i < RDL; i++) begin
            logic [INST_W-1:0] ei;
            logic [PC_W-1:0]   ep;
            ei = '0;
            ep = '0;
            if (i < sz) begin
                ei = exp_q[i][INST_W-1:0];
                ep = exp_q[i][PC_W+INST_W-1:INST_W];
            end
            chk($sformatf("%s_vld%0d", tag, i), 128'(bus.rd_vld_o[i]), 128'(i < sz));
            chk($sformatf("%s_inst%0d", tag, i), 128'(bus.rd_inst_o[i*INST_W +: INST_W]), 128'(ei));
            chk($sformatf("%s_pc%0d", tag, i), 128'(bus.rd_pc_o[i*PC_W +: PC_W]), 128'(ep));
        end
    endtask

    // driver: one cycle of write/pop/flush, model update, then check after the edge
    task automatic step(input logic [WRL-1:0] vld, input int pop, input logic flush,
                        input string tag);
        int   sz;
        int   avail;
        int   p;
        logic acc;
        for (int i = 0; i < WRL; i++) begin
            last_inst[i] = $urandom;
            last_pc[i]   = pc_ctr;
            if (vld[i]) pc_ctr = pc_ctr + 64'd4;
            bus.wr_inst_i[i*INST_W +: INST_W] = last_inst[i];
            bus.wr_pc_i[i*PC_W +: PC_W]       = last_pc[i];
        end
        bus.wr_vld_i = vld;
        bus.rd_pop_i = 3'(pop);
        bus.flush_i  = flush;
        if (!flush) chk($sformatf("%s_poplegal", tag), 128'(pop <= $countones(bus.rd_vld_o)), 128'(1));
        sz    = exp_q.size();
        avail = (sz < RDL) ? sz : RDL;
        acc   = (|vld) && ((DEPTH - sz) >= WRL) && !flush;
        p     = flush ? 0 : ((pop > avail) ? avail : pop);
        if (flush) exp_q.delete();
        else repeat (p) void'(exp_q.pop_front());
        if (acc) begin
            for (int i = 0; i < WRL; i++) begin
                if (vld[i]) exp_q.push_back({last_pc[i], last_inst[i]});
            end
        end
        @(posedge clock);
        #1;
        bus.wr_vld_i = '0;
        bus.rd_pop_i = '0;
        bus.flush_i  = 1'b0;
        check_state(tag);
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        pc_ctr       = 64'h1000;
        reset_n      = 1'b0;
        bus.flush_i  = 1'b0;
        bus.wr_vld_i = '0;
        bus.wr_inst_i = '0;
        bus.wr_pc_i  = '0;
        bus.rd_pop_i = '0;
        #12;
        check_state("reset");
        #8;
        reset_n = 1'b1;
        #1;
        check_state("post_reset");

        // sparse write compacts lanes 0,2,5,7
        step(8'b1010_0101, 0, 1'b0, "sparse");
        chk("sparse_cnt4", 128'(bus.count_o), 128'(4));
        chk("sparse_lane0", 128'(bus.rd_inst_o[0*INST_W +: INST_W]), 128'(last_inst[0]));
        chk("sparse_lane1", 128'(bus.rd_inst_o[1*INST_W +: INST_W]), 128'(last_inst[2]));
        chk("sparse_lane2", 128'(bus.rd_inst_o[2*INST_W +: INST_W]), 128'(last_inst[5]));
        chk("sparse_lane3", 128'(bus.rd_inst_o[3*INST_W +: INST_W]), 128'(last_inst[7]));
        step('0, 4, 1'b0, "sparse_pop");

        // fill to the top, then a write that must be refused
        step(8'hff, 0, 1'b0, "fill8");
        step(8'hff, 0, 1'b0, "fill16");
        chk("fill16_full", 128'(bus.full_o), 128'(1));
        step(8'hff, 0, 1'b0, "fill_refused");
        chk("fill_hold16", 128'(bus.count_o), 128'(16));
        for (int k = 0; k < 4; k++) step('0, 4, 1'b0, "drain");

        // flush beats a same-cycle write and pop
        step(8'h3f, 0, 1'b0, "pre_flush");
        step(8'hff, 4, 1'b1, "flush");
        chk("flush_empty", 128'(bus.empty_o), 128'(1));
        step('0, 0, 1'b0, "post_flush");

        // wrap past the last slot
        step(8'hff, 0, 1'b0, "wrap_fill8");
        step(8'h0f, 0, 1'b0, "wrap_fill12");
        for (int k = 0; k < 3; k++) step('0, 4, 1'b0, "wrap_pop");
        step(8'hff, 0, 1'b0, "wrap_write");
        step('0, 4, 1'b0, "wrap_read0");
        step('0, 4, 1'b0, "wrap_read1");

        // simultaneous write and pop
        step(8'h1f, 0, 1'b0, "simul_pre");
        step(8'hff, 3, 1'b0, "simul");
        chk("simul_cnt10", 128'(bus.count_o), 128'(10));

        // asynchronous reset in the middle of a cycle
        #3;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check_state("async_reset");
        #3;
        reset_n = 1'b1;

        // random traffic with legal pops and occasional flush
        for (int k = 0; k < 80; k++) begin
            int sz;
            int avail;
            sz    = exp_q.size();
            avail = (sz < RDL) ? sz : RDL;
            step(WRL'($urandom_range(0, 255)), $urandom_range(0, avail),
                 ($urandom_range(0, 19) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
